// File: rtl/jtag_dr_serializer_if.sv
// FIFO-side bundle for the JTAG DR serializer: the TCK-domain FIFO
// presents empty/head word (FWFT) and the serializer returns a pop strobe.
//   fifo_empty : FIFO has no word
//   fifo_data  : FIFO head word, valid while !fifo_empty
//   fifo_rd_en : pop head on the same TCK rising edge
interface jtag_dr_serializer_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );
endinterface

// File: rtl/jtag_dr_serializer.sv
// JTAG data-register serializer: streams FIFO words out of TDO as
// WIDTH+1-bit frames {data, valid}, LSB first, back to back while Shift-DR.
//   TCK, TRST          : test clock, async active-low reset
//   capture_dr/shift_dr: TAP state qualifiers for this register
//   fifo (slave)       : FIFO empty/head word in, pop strobe out
//   tdo, busy          : serial output (falling edge), SHIFT state
//   underrun_cnt       : frames loaded from an empty FIFO (saturating)
//   drop_cnt           : popped words abandoned before completion (saturating)
module jtag_dr_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             capture_dr,
    input  logic             shift_dr,
    jtag_dr_serializer_if.slave fifo,
    output logic             tdo,
    output logic             busy,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST = BW'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0] under_q, under_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             tdo_q;

    logic in_shift;
    logic reload;
    logic load;
    logic do_shift;
    logic abandon;

    assign in_shift = (state_q == SHIFT);
    // Last bit is on TDO; this edge completes the frame and fetches the next.
    assign reload   = in_shift & shift_dr & (bit_cnt_q == LAST);
    assign load     = capture_dr | reload;
    assign do_shift = in_shift & shift_dr & ~capture_dr & (bit_cnt_q != LAST);
    // Leaving SHIFT, or re-capturing anywhere but the reload edge, loses the word.
    assign abandon  = in_shift & frame_valid_q &
                      ((~capture_dr & ~shift_dr) | (capture_dr & ~reload));

    assign fifo.fifo_rd_en = load & ~fifo.fifo_empty & TRST;

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        frame_valid_d = frame_valid_q;
        under_d       = under_q;
        drop_d        = drop_q;

        if (load) begin
            sr_d          = fifo.fifo_empty ? '0 : {fifo.fifo_data, 1'b1};
            bit_cnt_d     = '0;
            frame_valid_d = ~fifo.fifo_empty;
            if (fifo.fifo_empty && under_q != '1)
                under_d = under_q + 1'b1;
        end else if (do_shift) begin
            sr_d      = {1'b0, sr_q[WIDTH:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (abandon && drop_q != '1)
            drop_d = drop_q + 1'b1;

        unique case (state_q)
            IDLE:    if (capture_dr) state_d = SHIFT;
            SHIFT:   if (!capture_dr && !shift_dr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            under_q       <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_valid_q <= frame_valid_d;
            under_q       <= under_d;
            drop_q        <= drop_d;
        end
    end

    // TDO launches on the falling edge so the TAP samples it on the next rise.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) tdo_q <= 1'b0;
        else       tdo_q <= sr_q[0];
    end

    assign tdo          = tdo_q;
    assign busy         = in_shift;
    assign underrun_cnt = under_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_jtag_dr_serializer.sv
// Bench for jtag_dr_serializer: directed frame scenarios plus random
// TAP/FIFO traffic against a frame-as-bit-queue reference model.
module tb_jtag_dr_serializer;
    localparam int W  = 8;
    localparam int CW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic TCK = 1'b0;
    logic TRST = 1'b0;
    logic capture_dr = 1'b0;
    logic shift_dr = 1'b0;
    logic tdo, busy;
    logic [CW-1:0] underrun_cnt, drop_cnt;

    jtag_dr_serializer_if #(.WIDTH(W)) fif();

    jtag_dr_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .TCK          (TCK),
        .TRST         (TRST),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .fifo         (fif.slave),
        .tdo          (tdo),
        .busy         (busy),
        .underrun_cnt (underrun_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [31:0] tlog = '0;

    logic [W-1:0] q[$];
    bit m_frm[$];
    bit m_act = 0;
    bit m_val = 0;
    int m_und = 0;
    int m_drp = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic upd_fifo();
        fif.fifo_empty = (q.size() == 0);
        fif.fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    // One TCK cycle; called at falling edge + 1.
    task automatic step(input bit cap, input bit sh);
        bit emp, rl, ld, pop;
        logic [W-1:0] d;
        int n;
        capture_dr = cap;
        shift_dr   = sh;
        upd_fifo();
        #2;
        emp = (q.size() == 0);
        d   = emp ? '0 : q[0];
        n   = m_frm.size();
        rl  = m_act && sh && (n == 1);
        ld  = cap || rl;
        pop = ld && !emp;
        chk("rd_en", 32'(fif.fifo_rd_en), 32'(pop));
        if (fif.fifo_rd_en) pops++;
        @(posedge TCK);
        if (m_act && m_val && ((!cap && !sh) || (cap && !rl)))
            m_drp = sat(m_drp + 1);
        if (ld) begin
            if (emp) m_und = sat(m_und + 1);
            m_frm.delete();
            m_frm.push_back(!emp);
            for (int i = 0; i < W; i++) m_frm.push_back(emp ? 1'b0 : d[i]);
            m_val = !emp;
        end else if (m_act && sh && n > 1) begin
            void'(m_frm.pop_front());
        end
        m_act = cap || (m_act && sh);
        if (pop) void'(q.pop_front());
        #1;
        upd_fifo();
        chk("busy", 32'(busy), 32'(m_act));
        chk("underrun", 32'(underrun_cnt), 32'(m_und));
        chk("drop", 32'(drop_cnt), 32'(m_drp));
        @(negedge TCK);
        #1;
        chk("tdo", 32'(tdo), (m_frm.size() != 0) ? 32'(m_frm[0]) : 32'd0);
        tlog = {tlog[30:0], tdo};
    endtask

    task automatic do_reset(input bit hold_cap);
        TRST       = 1'b0;
        capture_dr = hold_cap;
        shift_dr   = 1'b0;
        upd_fifo();
        #1;
        chk("rst_tdo", 32'(tdo), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_under", 32'(underrun_cnt), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_rd_en", 32'(fif.fifo_rd_en), 0);
        m_frm.delete();
        m_act = 0;
        m_val = 0;
        m_und = 0;
        m_drp = 0;
        @(posedge TCK);
        #1;
        chk("rst_rd_en_edge", 32'(fif.fifo_rd_en), 0);
        if (fif.fifo_rd_en) pops++;
        @(negedge TCK);
        #1;
        TRST       = 1'b1;
        capture_dr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        upd_fifo();
        @(negedge TCK);
        #1;

        // 0xA5: one frame then reload from an empty FIFO
        q.delete();
        do_reset(0);
        q.push_back(8'hA5);
        pops = 0;
        tlog = '0;
        step(1, 0);
        repeat (8) step(0, 1);
        chk("a5_seq", {23'd0, tlog[8:0]}, 32'b110100101);
        chk("a5_busy", 32'(busy), 1);
        step(0, 1);
        chk("a5_pops", pops, 1);

        // 0x3C, 0x81 back to back
        q.delete();
        do_reset(0);
        q.push_back(8'h3C);
        q.push_back(8'h81);
        pops = 0;
        tlog = '0;
        step(1, 0);
        repeat (8) step(0, 1);
        chk("w1_seq", {23'd0, tlog[8:0]}, 32'b100111100);
        chk("w1_pops", pops, 1);
        tlog = '0;
        repeat (9) step(0, 1);
        chk("w2_seq", {23'd0, tlog[8:0]}, 32'b110000001);
        step(0, 1);
        chk("w2_pops", pops, 2);

        // empty FIFO: filler frame
        q.delete();
        do_reset(0);
        pops = 0;
        tlog = '0;
        step(1, 0);
        repeat (8) step(0, 1);
        chk("empty_seq", {23'd0, tlog[8:0]}, 0);
        chk("empty_under", 32'(underrun_cnt), 1);
        step(0, 1);
        chk("empty_pops", pops, 0);

        // 0xFF abandoned after 4 shifts
        q.delete();
        do_reset(0);
        q.push_back(8'hFF);
        pops = 0;
        step(1, 0);
        repeat (4) step(0, 1);
        step(0, 0);
        chk("abandon_busy", 32'(busy), 0);
        chk("abandon_drop", 32'(drop_cnt), 1);
        chk("abandon_pops", pops, 1);

        // capture and shift together: load wins
        q.delete();
        do_reset(0);
        q.push_back(8'h55);
        pops = 0;
        tlog = '0;
        step(1, 1);
        repeat (3) step(0, 1);
        chk("both_seq", {28'd0, tlog[3:0]}, 32'b1101);
        chk("both_pops", pops, 1);

        // TRST mid-frame
        q.delete();
        do_reset(0);
        q.push_back(8'hA5);
        step(1, 0);
        repeat (5) step(0, 1);
        q.push_back(8'h3C);
        do_reset(1);
        pops = 0;
        step(0, 1);
        step(0, 0);
        chk("trst_pops", pops, 0);
        chk("trst_drop", 32'(drop_cnt), 0);

        // random traffic, counters saturate at 3 bits
        q.delete();
        do_reset(0);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(2) == 0 && q.size() < 4)
                q.push_back(W'($urandom));
            if ($urandom_range(199) == 0)
                do_reset($urandom_range(1) == 1);
            else
                step($urandom_range(11) == 0, $urandom_range(9) < 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
